queue_drain_ctrl: RTL and testbench



---
 rtl/queue_drain_ctrl.sv | 126 ++++++++++++
 tb/tb_queue_drain_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/queue_drain_ctrl.sv
// queue_drain_ctrl: pops words from the byte queue and hands them to a downstream
// valid/ready consumer. It also drives the deserializer ready line with watermark
// hysteresis and raises a sticky flag when the queue is seen full.
module queue_drain_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HIGH_WM = 7,
  parameter int unsigned LOW_WM  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LEN_W-1:0]  q_len_in,
  input  logic [DATA_W-1:0] q_data_in,
  output logic              q_dequeue_out,
  output logic              des_ready_out,
  input  logic              drain_en_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        drained_cnt_out,
  output logic              full_err_out
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    SETTLE  = 2'd2,
    PRESENT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                deq_q, deq_d;
  logic                valid_q, valid_d;
  logic                des_ready_q, des_ready_d;
  logic                full_err_q, full_err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and next values of every registered output
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    des_ready_d = des_ready_q;
    full_err_d  = full_err_q;

    case (state_q)
      IDLE: begin
        if (drain_en_in && (q_len_in != '0)) begin
          state_d = POP;
        end
      end
      POP: begin
        // Head word is still valid here; the queue pops at the end of this cycle.
        data_d  = q_data_in;
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobe and valid are registered decodes of the upcoming state.
    deq_d   = (state_d == POP);
    valid_d = (state_d == PRESENT);

    // Hysteresis between the two watermarks; in between, hold.
    if (q_len_in >= LEN_W'(HIGH_WM)) begin
      des_ready_d = 1'b0;
    end else if (q_len_in <= LEN_W'(LOW_WM)) begin
      des_ready_d = 1'b1;
    end

    if (q_len_in == LEN_W'(DEPTH)) begin
      full_err_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      deq_q       <= 1'b0;
      valid_q     <= 1'b0;
      des_ready_q <= 1'b0;
      full_err_q  <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
    end else begin
      deq_q       <= deq_d;
      valid_q     <= valid_d;
      des_ready_q <= des_ready_d;
      full_err_q  <= full_err_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign q_dequeue_out   = deq_q;
  assign out_valid       = valid_q;
  assign des_ready_out   = des_ready_q;
  assign full_err_out    = full_err_q;
  assign out_data        = data_q;
  assign drained_cnt_out = cnt_q;

endmodule

// File: tb/tb_queue_drain_ctrl.sv
// Bench for queue_drain_ctrl: behavioural queue model, directed stimulus and a
// scoreboard of expected output words checked by a monitor on every handshake.
module tb_queue_drain_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] q_len_in;
  logic [7:0] q_data_in;
  logic       q_dequeue_out;
  logic       des_ready_out;
  logic       drain_en_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] drained_cnt_out;
  logic       full_err_out;

  // Queue model: circular memory with head index and occupancy
  logic [7:0] mdl_mem [16];
  logic [3:0] mdl_head;
  logic [3:0] mdl_len;

  logic [7:0] exp_q [$];
  int         checks;
  int         errors;
  int         strobes;
  logic       prev_deq;

  assign q_len_in  = mdl_len;
  assign q_data_in = mdl_mem[mdl_head];

  queue_drain_ctrl #(
    .DATA_W (8),
    .LEN_W  (4),
    .DEPTH  (8),
    .HIGH_WM(7),
    .LOW_WM (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .q_len_in       (q_len_in),
    .q_data_in      (q_data_in),
    .q_dequeue_out  (q_dequeue_out),
    .des_ready_out  (des_ready_out),
    .drain_en_in    (drain_en_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .drained_cnt_out(drained_cnt_out),
    .full_err_out   (full_err_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    mdl_mem[4'(mdl_head + mdl_len)] = d;
    mdl_len = mdl_len + 4'd1;
  endtask

  // Advance one cycle; the queue pops at the edge that ends a strobe cycle.
  task automatic step();
    logic deq;
    @(negedge clock);
    deq = q_dequeue_out;
    if (deq) begin
      check("no_back_to_back_strobe", 32'(prev_deq), 32'd0);
      strobes++;
    end
    prev_deq = deq;
    @(posedge clock);
    #1;
    if (deq && !reset && mdl_len != 4'd0) begin
      mdl_head = mdl_head + 4'd1;
      mdl_len  = mdl_len - 4'd1;
    end
  endtask

  // Monitor: compares every accepted word against the scoreboard
  task automatic monitor();
    logic       pv, pr;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pd = 8'd0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (pv && !pr && out_valid) begin
          check("out_data_stable", 32'(out_data), 32'(pd));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            check("scoreboard_data", 32'(out_data), 32'(exp_q.pop_front()));
          end
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data;
    end
  endtask

  initial begin
    int n;
    int s0;
    logic [3:0] wm_len [7];
    logic       wm_exp [7];
    checks = 0; errors = 0; strobes = 0; prev_deq = 1'b0;
    mdl_head = 4'd0; mdl_len = 4'd0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'd0;
    reset = 1'b1; drain_en_in = 1'b0; out_ready = 1'b0;
    fork monitor(); join_none

    // 1: reset held three cycles, then released with an empty queue
    for (int i = 0; i < 3; i++) step();
    check("rst_deq", 32'(q_dequeue_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_cnt", 32'(drained_cnt_out), 32'd0);
    check("rst_full_err", 32'(full_err_out), 32'd0);
    check("rst_des_ready", 32'(des_ready_out), 32'd0);
    reset = 1'b0;
    step();
    check("des_ready_after_release", 32'(des_ready_out), 32'd1);

    // 2: single word, latency of strobe and valid
    push_word(8'h80); exp_q.push_back(8'h80);
    drain_en_in = 1'b1; out_ready = 1'b1;
    step();
    check("t2_strobe_n1", 32'(q_dequeue_out), 32'd1);
    drain_en_in = 1'b0;
    step();
    check("t2_strobe_n2", 32'(q_dequeue_out), 32'd0);
    check("t2_valid_n2", 32'(out_valid), 32'd0);
    check("t2_len_after_pop", 32'(mdl_len), 32'd0);
    step();
    check("t2_valid_n3", 32'(out_valid), 32'd1);
    check("t2_data_n3", 32'(out_data), 32'h80);
    step();
    check("t2_valid_n4", 32'(out_valid), 32'd0);
    check("t2_cnt", 32'(drained_cnt_out), 32'd1);
    check("t2_full_err", 32'(full_err_out), 32'd0);

    // 3: full queue drained in order
    for (int i = 0; i < 8; i++) begin
      push_word(8'(8'h80 + i));
      exp_q.push_back(8'(8'h80 + i));
    end
    s0 = strobes;
    drain_en_in = 1'b1;
    n = 0;
    while (drained_cnt_out != 8'd9 && n < 100) begin step(); n++; end
    drain_en_in = 1'b0;
    check("t3_cnt", 32'(drained_cnt_out), 32'd9);
    check("t3_strobes", 32'(strobes - s0), 32'd8);
    check("t3_full_err", 32'(full_err_out), 32'd1);
    check("t3_len_end", 32'(mdl_len), 32'd0);
    step();

    // 4: watermark hysteresis sweep
    wm_len = '{4'd0, 4'd3, 4'd6, 4'd7, 4'd5, 4'd3, 4'd2};
    wm_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      mdl_len = wm_len[i];
      step();
      check($sformatf("t4_des_ready_len%0d", wm_len[i]), 32'(des_ready_out), 32'(wm_exp[i]));
    end
    mdl_len = 4'd0;
    step();

    // 5: consumer back-pressure for 20 cycles
    push_word(8'h42); push_word(8'h43);
    exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    drain_en_in = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    check("t5_valid_rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_data", 32'(out_data), 32'h42);
      check("t5_hold_no_strobe", 32'(q_dequeue_out), 32'd0);
      check("t5_hold_cnt", 32'(drained_cnt_out), 32'd9);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t5_cnt_accept", 32'(drained_cnt_out), 32'd10);
    check("t5_valid_drop", 32'(out_valid), 32'd0);
    n = 0;
    while (drained_cnt_out != 8'd11 && n < 20) begin step(); n++; end
    check("t5_cnt_second", 32'(drained_cnt_out), 32'd11);
    drain_en_in = 1'b0; out_ready = 1'b0;
    step();

    // 6: reset while a word is presented; it is discarded
    push_word(8'h85); push_word(8'h86);
    exp_q.push_back(8'h86);
    drain_en_in = 1'b1;
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    check("t6_present_data", 32'(out_data), 32'h85);
    reset = 1'b1;
    step();
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_cnt", 32'(drained_cnt_out), 32'd0);
    check("t6_rst_deq", 32'(q_dequeue_out), 32'd0);
    check("t6_rst_full_err", 32'(full_err_out), 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    n = 0;
    while (drained_cnt_out != 8'd1 && n < 20) begin step(); n++; end
    check("t6_cnt_resume", 32'(drained_cnt_out), 32'd1);
    check("t6_len_end", 32'(mdl_len), 32'd0);
    drain_en_in = 1'b0;
    step(); step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
